obi_addr_demux: RTL and testbench



---
 rtl/obi_addr_demux.sv | 124 ++++++++++++
 tb/tb_obi_addr_demux.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_addr_demux.sv
// OBI request demultiplexer. It routes one initiator to NUM_TARGETS targets by address rule,
// keeps responses in order, and answers unmapped addresses with an internal error response.
module obi_addr_demux #(
  parameter int NUM_TARGETS     = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_TARGETS*64-1:0] rules_i,
  input  logic                     m_req_i,
  output logic                     m_gnt_o,
  input  logic [31:0]              m_addr_i,
  input  logic                     m_we_i,
  input  logic [3:0]               m_be_i,
  input  logic [31:0]              m_wdata_i,
  output logic                     m_rvalid_o,
  output logic [31:0]              m_rdata_o,
  output logic                     m_err_o,
  output logic [NUM_TARGETS-1:0]   t_req_o,
  input  logic [NUM_TARGETS-1:0]   t_gnt_i,
  output logic [31:0]              t_addr_o,
  output logic                     t_we_o,
  output logic [3:0]               t_be_o,
  output logic [31:0]              t_wdata_o,
  input  logic [NUM_TARGETS-1:0]   t_rvalid_i,
  input  logic [NUM_TARGETS*32-1:0] t_rdata_i,
  output logic                     protocol_err_o
);

  localparam int ID_W  = $clog2(NUM_TARGETS + 1);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ID_W-1:0]  ERR_ID  = ID_W'(NUM_TARGETS);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff;
  logic [ID_W-1:0]  act_id_q, act_id_d, sel_id;
  logic             err_pend_q, err_pend_d;
  logic             protocol_err_q, protocol_err_d;
  logic             sel_mapped, act_mapped, allow, accept, sel_gnt;

  // Scanning from the top down lets the lowest matching rule win.
  always_comb begin
    sel_id = ERR_ID;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (m_addr_i >= rules_i[i*64+32 +: 32] && m_addr_i < rules_i[i*64 +: 32]) begin
        sel_id = ID_W'(i);
      end
    end
  end

  assign sel_mapped = (sel_id != ERR_ID);
  assign act_mapped = (act_id_q != ERR_ID);

  always_comb begin
    m_rvalid_o = 1'b0;
    m_rdata_o  = '0;
    m_err_o    = 1'b0;
    if (act_mapped) begin
      for (int i = 0; i < NUM_TARGETS; i++) begin
        if (act_id_q == ID_W'(i) && cnt_q != '0 && t_rvalid_i[i]) begin
          m_rvalid_o = 1'b1;
          m_rdata_o  = t_rdata_i[i*32 +: 32];
        end
      end
    end else if (err_pend_q) begin
      m_rvalid_o = 1'b1;
      m_err_o    = 1'b1;
    end
  end

  // A response in this cycle already frees its slot, so a target switch can be granted alongside it.
  always_comb begin
    cnt_eff = cnt_q - CNT_W'(m_rvalid_o);
    allow   = (cnt_eff < MAX_CNT) && (cnt_eff == '0 || sel_id == act_id_q);
    sel_gnt = 1'b0;
    t_req_o = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (sel_id == ID_W'(i)) begin
        sel_gnt    = t_gnt_i[i];
        t_req_o[i] = m_req_i && allow;
      end
    end
    m_gnt_o = sel_mapped ? (sel_gnt && allow) : (m_req_i && allow);
    accept  = m_req_i && m_gnt_o;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !m_rvalid_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!accept && m_rvalid_o) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    act_id_d       = accept ? sel_id : act_id_q;
    err_pend_d     = accept && !sel_mapped;
    protocol_err_d = protocol_err_q;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (t_rvalid_i[i] && (cnt_q == '0 || act_id_q != ID_W'(i))) begin
        protocol_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q          <= '0;
      act_id_q       <= '0;
      err_pend_q     <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      act_id_q       <= act_id_d;
      err_pend_q     <= err_pend_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign protocol_err_o = protocol_err_q;
  assign t_addr_o       = m_addr_i;
  assign t_we_o         = m_we_i;
  assign t_be_o         = m_be_i;
  assign t_wdata_o      = m_wdata_i;

endmodule

// File: tb/tb_obi_addr_demux.sv
// Bench for obi_addr_demux: directed scenarios on SRAM/ROM rules, then random traffic
// checked against a queue-based model of outstanding transactions.
module tb_obi_addr_demux;

  localparam int NT  = 2;
  localparam int MAX = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [127:0]  rules;
  logic          m_req, m_gnt, m_we, m_rvalid, m_err, t_we, perr;
  logic [31:0]   m_addr, m_wdata, m_rdata, t_addr, t_wdata;
  logic [3:0]    m_be, t_be;
  logic [1:0]    t_req, t_gnt, t_rvalid;
  logic [63:0]   t_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] rstart [2];
  logic [31:0] rend   [2];

  typedef struct { int tgt; logic [31:0] data; int due; } tresp_t;
  typedef struct { int tgt; logic [31:0] data; int cyc; } rresp_t;
  tresp_t tq[$];
  rresp_t rq[$];

  obi_addr_demux #(.NUM_TARGETS(NT), .MAX_OUTSTANDING(MAX)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rules_i(rules),
    .m_req_i(m_req), .m_gnt_o(m_gnt), .m_addr_i(m_addr), .m_we_i(m_we),
    .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rvalid_o(m_rvalid),
    .m_rdata_o(m_rdata), .m_err_o(m_err), .t_req_o(t_req), .t_gnt_i(t_gnt),
    .t_addr_o(t_addr), .t_we_o(t_we), .t_be_o(t_be), .t_wdata_o(t_wdata),
    .t_rvalid_i(t_rvalid), .t_rdata_i(t_rdata), .protocol_err_o(perr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic checkRsp(input string tag, input logic v, input logic e, input logic [31:0] d);
    checkOutput(tag, {m_rvalid, m_err, m_rdata}, {v, e, d});
  endtask

  task automatic checkReq(input string tag, input logic g, input logic [1:0] r);
    checkOutput(tag, {m_gnt, t_req}, {g, r});
  endtask

  // Drives one cycle of stimulus just after the falling edge and settles before sampling.
  task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic [1:0] gnt,
                               input logic [1:0] rv, input logic [31:0] rd);
    @(negedge clk);
    m_req    = req;
    m_addr   = addr;
    t_gnt    = gnt;
    t_rvalid = rv;
    t_rdata  = {rd, rd};
    #1;
  endtask

  function automatic int refDecode(input logic [31:0] a);
    for (int i = 0; i < NT; i++) begin
      if (a >= rstart[i] && a < rend[i]) return i;
    end
    return NT;
  endfunction

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 6))
      0:       return 32'h2000_0000 + (32'($urandom_range(0, 2047)) << 2);
      1:       return 32'h2000_1FFC;
      2:       return 32'h2000_2000;
      3:       return 32'h3000_0000 + (32'($urandom_range(0, 255)) << 2);
      4:       return 32'h3000_0400;
      5:       return 32'h2FFF_FFFC;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic        req_active, exp_rv, exp_gnt, allowed, stop;
    logic [1:0]  exp_treq;
    logic [31:0] r_addr, r_wdata, exp_data, nd;
    logic [3:0]  r_be;
    logic        r_we;
    int          id, n, wait_cnt;

    rstart[0] = 32'h2000_0000; rend[0] = 32'h2000_2000;
    rstart[1] = 32'h3000_0000; rend[1] = 32'h3000_0400;
    rules = {rstart[1], rend[1], rstart[0], rend[0]};
    m_req = 0; m_addr = 0; m_we = 0; m_be = 0; m_wdata = 0;
    t_gnt = 0; t_rvalid = 0; t_rdata = 0;
    rst_n = 0;
    #1;
    checkOutput("reset_outputs", {m_gnt, t_req, m_rvalid, m_err, m_rdata, perr},
                {1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0});
    repeat (2) @(negedge clk);
    rst_n = 1;
    m_be  = 4'hF;

    // Scenario 1: SRAM read at the last word, response two cycles later.
    applyStimulus(1, 32'h2000_1FFC, 2'b01, 2'b00, 0);
    checkReq("t1_req", 1'b1, 2'b01);
    applyStimulus(0, 0, 2'b00, 2'b00, 0);
    checkRsp("t1_wait", 0, 0, 0);
    applyStimulus(0, 0, 2'b00, 2'b01, 32'hDEAD_BEEF);
    checkRsp("t1_rsp", 1, 0, 32'hDEAD_BEEF);

    // Scenario 2: exclusive end addresses are unmapped.
    applyStimulus(1, 32'h2000_2000, 2'b11, 2'b00, 0);
    checkReq("t2_req_a", 1'b1, 2'b00);
    checkRsp("t2_idle", 0, 0, 0);
    applyStimulus(1, 32'h3000_0400, 2'b11, 2'b00, 0);
    checkReq("t2_req_b", 1'b1, 2'b00);
    checkRsp("t2_err_a", 1, 1, 0);
    applyStimulus(0, 0, 2'b00, 2'b00, 0);
    checkRsp("t2_err_b", 1, 1, 0);
    applyStimulus(0, 0, 2'b00, 2'b00, 0);
    checkRsp("t2_done", 0, 0, 0);

    // Scenario 3: target switch blocked until the SRAM response.
    applyStimulus(1, 32'h2000_0010, 2'b01, 2'b00, 0);
    checkReq("t3_sram", 1'b1, 2'b01);
    applyStimulus(1, 32'h3000_0004, 2'b11, 2'b00, 0);
    checkReq("t3_block_a", 1'b0, 2'b00);
    applyStimulus(1, 32'h3000_0004, 2'b11, 2'b00, 0);
    checkReq("t3_block_b", 1'b0, 2'b00);
    applyStimulus(1, 32'h3000_0004, 2'b00, 2'b01, 32'h1111_1111);
    checkReq("t3_switch_nognt", 1'b0, 2'b10);
    checkRsp("t3_sram_rsp", 1, 0, 32'h1111_1111);
    applyStimulus(1, 32'h3000_0004, 2'b10, 2'b00, 0);
    checkReq("t3_switch_gnt", 1'b1, 2'b10);
    applyStimulus(0, 0, 2'b00, 2'b10, 32'h2222_2222);
    checkRsp("t3_rom_rsp", 1, 0, 32'h2222_2222);

    // Scenario 4: outstanding limit with three back-to-back ROM reads.
    for (int k = 0; k < 12; k++) begin
      logic        rv;
      logic [31:0] a;
      rv = (k == 5 || k == 6 || k == 10);
      a  = 32'h3000_0000 + 32'(k < 2 ? k * 4 : 8);
      applyStimulus(k <= 5, a, 2'b11, rv ? 2'b10 : 2'b00, 32'hA000_0000 + 32'(k));
      if (k <= 5) checkReq($sformatf("t4_gnt_%0d", k), (k <= 1 || k == 5), (k <= 1 || k == 5) ? 2'b10 : 2'b00);
      checkRsp($sformatf("t4_rsp_%0d", k), rv, 0, rv ? 32'hA000_0000 + 32'(k) : 32'h0);
    end

    // Scenario 5: stray response while idle sets the sticky protocol error.
    applyStimulus(0, 0, 2'b00, 2'b10, 32'h5555_5555);
    checkRsp("t5_drop", 0, 0, 0);
    checkOutput("t5_perr_now", perr, 0);
    applyStimulus(0, 0, 2'b00, 2'b00, 0);
    checkOutput("t5_perr_set", perr, 1);
    applyStimulus(1, 32'h2000_0040, 2'b01, 2'b00, 0);
    checkReq("t5_good_req", 1'b1, 2'b01);
    applyStimulus(0, 0, 2'b00, 2'b01, 32'h7777_0000);
    checkRsp("t5_good_rsp", 1, 0, 32'h7777_0000);
    checkOutput("t5_perr_sticky", perr, 1);

    // Scenario 6: reset with one transaction outstanding.
    applyStimulus(1, 32'h2000_0100, 2'b01, 2'b00, 0);
    checkReq("t6_pre", 1'b1, 2'b01);
    @(negedge clk);
    rst_n = 0; m_req = 0; m_addr = 0; m_be = 0; t_gnt = 0; t_rvalid = 0; t_rdata = 0;
    #1;
    checkOutput("t6_reset_outputs", {m_gnt, t_req, m_rvalid, m_err, m_rdata, perr, t_addr, t_be},
                {1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0});
    @(negedge clk);
    rst_n = 1;
    m_we = 1; m_be = 4'hF; m_wdata = 32'h1234_5678;
    applyStimulus(1, 32'h2000_0000, 2'b01, 2'b00, 0);
    checkReq("t6_write_req", 1'b1, 2'b01);
    checkOutput("t6_bcast", {t_addr, t_we, t_be, t_wdata}, {32'h2000_0000, 1'b1, 4'hF, 32'h1234_5678});
    m_we = 0; m_wdata = 0;
    applyStimulus(0, 0, 2'b00, 2'b01, 0);
    checkRsp("t6_write_rsp", 1, 0, 0);
    applyStimulus(1, 32'h3000_0000, 2'b10, 2'b00, 0);
    checkReq("t6_switch_free", 1'b1, 2'b10);
    applyStimulus(0, 0, 2'b00, 2'b10, 32'hC0DE_0001);
    checkRsp("t6_rom_rsp", 1, 0, 32'hC0DE_0001);
    checkOutput("t6_perr_clear", perr, 0);

    // Random traffic with random target grants and response delays.
    req_active = 0; r_addr = 0; r_we = 0; r_be = 0; r_wdata = 0; wait_cnt = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      stop = (cyc >= 3000);
      if (stop && rq.size() == 0 && !req_active) break;
      @(negedge clk);
      if (!req_active && !stop && $urandom_range(0, 3) != 0) begin
        req_active = 1;
        r_addr  = randAddr();
        r_we    = 1'($urandom);
        r_be    = 4'($urandom);
        r_wdata = $urandom;
        wait_cnt = 0;
      end
      m_req = req_active; m_addr = r_addr; m_we = r_we; m_be = r_be; m_wdata = r_wdata;
      t_gnt = 2'($urandom);
      t_rvalid = 0; t_rdata = 0;
      if (tq.size() > 0 && tq[0].due <= cyc) begin
        t_rvalid[tq[0].tgt] = 1'b1;
        t_rdata[tq[0].tgt*32 +: 32] = tq[0].data;
        void'(tq.pop_front());
      end
      #1;
      exp_rv = (t_rvalid != 2'b00) || (rq.size() > 0 && rq[0].tgt == NT && rq[0].cyc + 1 == cyc);
      exp_data = 0;
      if (exp_rv) begin
        exp_data = rq[0].data;
        checkRsp("rnd_rsp", 1, rq[0].tgt == NT, exp_data);
        void'(rq.pop_front());
      end else begin
        checkRsp("rnd_idle", 0, 0, 0);
      end
      checkOutput("rnd_perr", perr, 0);
      if (req_active) begin
        id = refDecode(r_addr);
        n  = rq.size();
        allowed  = (n < MAX) && (n == 0 || rq[n-1].tgt == id);
        exp_gnt  = allowed && (id == NT || t_gnt[id]);
        exp_treq = (allowed && id < NT) ? 2'(1 << id) : 2'b00;
        checkReq("rnd_req", exp_gnt, exp_treq);
        checkOutput("rnd_bcast", {t_addr, t_we, t_be, t_wdata}, {r_addr, r_we, r_be, r_wdata});
        if (exp_gnt) begin
          nd = $urandom;
          if (id < NT) tq.push_back('{id, nd, cyc + 1 + $urandom_range(0, 3)});
          rq.push_back('{id, (id < NT) ? nd : 32'h0, cyc});
          req_active = 0;
        end else begin
          wait_cnt++;
          if (wait_cnt > 64) begin
            checkOutput("rnd_timeout", 1, 0);
            req_active = 0;
          end
        end
      end
    end
    checkOutput("rnd_drain", 96'(rq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
